// File: rtl/jpeg_idct_pkg.sv
// Shared constants and helpers for the IDCT row pass.
// Latency: n/a (package). Backpressure: n/a.
// Holds datapath widths, output saturation limits and the cosine-coefficient generator.
package jpeg_idct_pkg;

  localparam int COEF_W = 13;  // signed fixed-point cosine coefficient
  localparam int IN_W   = 16;  // signed dequantised coefficient
  localparam int ACC_W  = 32;  // signed multiply-accumulator
  localparam int OUT_W  = 21;  // signed result to the transpose buffer
  localparam int PROD_W = COEF_W + IN_W;
  // Two guard bits above the accumulator so the final add and rounding term cannot wrap.
  localparam int SUM_W  = ACC_W + 2;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 34'sd1048575;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -34'sd1048576;

  // C(n,k) = round(4096 * c(k)/2 * cos((2n+1)k*pi/16)).
  // For k>0 the angle index m=(2n+1)k is folded into the first quadrant, so one
  // eight-entry magnitude table plus a sign covers every (n,k) pair.
  function automatic logic signed [COEF_W-1:0] coef_val(input int n, input int k);
    int m;
    logic neg;
    logic signed [COEF_W-1:0] mag;
    if (k == 0) begin
      return 13'sd1448;
    end
    m   = ((2 * n + 1) * k) & 31;
    neg = 1'b0;
    if (m > 16) m = 32 - m;                 // cos(2pi - a) = cos(a)
    if (m > 8) begin                        // cos(pi - a) = -cos(a)
      m   = 16 - m;
      neg = 1'b1;
    end
    case (m)
      1:       mag = 13'sd2009;
      2:       mag = 13'sd1892;
      3:       mag = 13'sd1703;
      4:       mag = 13'sd1448;
      5:       mag = 13'sd1138;
      6:       mag = 13'sd784;
      7:       mag = 13'sd400;
      8:       mag = 13'sd0;
      default: mag = 13'sd2048;
    endcase
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/jpeg_idct_row_coef.sv
// Cosine coefficient ROM: returns C(0..7,k) for the column index k of the current input.
// Latency: combinational. Backpressure: none (pure lookup).
// Ports: k_i - coefficient index; coef_o - eight packed 13-bit signed values, slot n at [n*13 +: 13].
module jpeg_idct_row_coef
  import jpeg_idct_pkg::*;
(
  input  logic [2:0]            k_i,
  output logic [8*COEF_W-1:0]   coef_o
);

  always_comb begin
    coef_o = '0;
    for (int n = 0; n < 8; n++) begin
      coef_o[n*COEF_W +: COEF_W] = coef_val(n, int'(k_i));
    end
  end

endmodule

// File: rtl/jpeg_idct_row.sv
// First (row) pass of the 2-D IDCT: eight parallel MACs turn one row of X[k] into y[0..7].
// Latency: first result the cycle after the k=7 input; 8 cycles per row, no bubbles with ready high.
// Backpressure: k=0..6 always accepted; k=7 held off while the previous row is still draining.
// Ports: clk_i/rst_i (sync, active-high); img_start_i flushes all state; img_end_i unused;
//        inport_* coefficient stream {row,k}; outport_* result stream {row,n} with ready.
module jpeg_idct_row
  import jpeg_idct_pkg::*;
#(
  parameter int OUT_SHIFT = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               img_start_i,
  input  logic               img_end_i,
  input  logic               inport_valid_i,
  input  logic [IN_W-1:0]    inport_data_i,
  input  logic [5:0]         inport_idx_i,
  output logic               inport_accept_o,
  output logic               outport_valid_o,
  output logic [OUT_W-1:0]   outport_data_o,
  output logic [5:0]         outport_idx_o,
  input  logic               outport_ready_i
);

  // Round-half-up term; absent when no shift is applied.
  localparam int     RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam longint RND_L  = (OUT_SHIFT > 0) ? (64'sd1 <<< RND_SH) : 64'sd0;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(RND_L);

  logic                      unused_img_end;
  logic [2:0]                in_k;
  logic [2:0]                in_row;
  logic signed [IN_W-1:0]    in_x;
  logic [8*COEF_W-1:0]       coef_flat;

  logic signed [ACC_W-1:0]   acc_q   [8];
  logic signed [ACC_W-1:0]   acc_nxt [8];
  logic signed [PROD_W-1:0]  prod    [8];
  logic signed [SUM_W-1:0]   sum     [8];
  logic signed [SUM_W-1:0]   shf     [8];
  logic signed [OUT_W-1:0]   res_nxt [8];
  logic signed [OUT_W-1:0]   res_q   [8];

  logic [2:0]                n_q;
  logic [2:0]                row_q;
  logic                      in_xfer;
  logic                      out_xfer;
  logic                      last_beat;

  assign unused_img_end = img_end_i;

  assign in_k   = inport_idx_i[2:0];
  assign in_row = inport_idx_i[5:3];
  assign in_x   = $signed(inport_data_i);

  jpeg_idct_row_coef u_coef (
    .k_i    (in_k),
    .coef_o (coef_flat)
  );

  // outport_valid_o doubles as the "buffer full" flag.
  assign out_xfer  = outport_valid_o && outport_ready_i;
  assign last_beat = out_xfer && (n_q == 3'd7);

  // Only a row completion needs the buffer; it may land on the final drain beat.
  assign inport_accept_o = !(outport_valid_o && (in_k == 3'd7) && !last_beat);
  assign in_xfer         = inport_valid_i && inport_accept_o;

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      prod[n]    = $signed(coef_flat[n*COEF_W +: COEF_W]) * in_x;
      // k=0 starts a new row, discarding the previous partial sums.
      acc_nxt[n] = (in_k == 3'd0) ? ACC_W'(prod[n]) : (acc_q[n] + ACC_W'(prod[n]));
      sum[n]     = SUM_W'(acc_q[n]) + SUM_W'(prod[n]) + RND;
      shf[n]     = sum[n] >>> OUT_SHIFT;
      if (shf[n] > SAT_MAX) begin
        res_nxt[n] = SAT_MAX[OUT_W-1:0];
      end else if (shf[n] < SAT_MIN) begin
        res_nxt[n] = SAT_MIN[OUT_W-1:0];
      end else begin
        res_nxt[n] = shf[n][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || img_start_i) begin
      // img_start_i flushes exactly like reset; any same-cycle input is dropped.
      for (int n = 0; n < 8; n++) begin
        acc_q[n] <= '0;
        res_q[n] <= '0;
      end
      outport_valid_o <= 1'b0;
      outport_data_o  <= '0;
      outport_idx_o   <= '0;
      n_q             <= '0;
      row_q           <= '0;
    end else begin
      if (in_xfer && (in_k != 3'd7)) begin
        for (int n = 0; n < 8; n++) begin
          acc_q[n] <= acc_nxt[n];
        end
      end

      if (in_xfer && (in_k == 3'd7)) begin
        // Row complete: load the buffer and present slot 0 next cycle.
        for (int n = 0; n < 8; n++) begin
          res_q[n] <= res_nxt[n];
        end
        row_q           <= in_row;
        n_q             <= 3'd0;
        outport_valid_o <= 1'b1;
        outport_data_o  <= res_nxt[0];
        outport_idx_o   <= {in_row, 3'd0};
      end else if (out_xfer) begin
        if (n_q == 3'd7) begin
          outport_valid_o <= 1'b0;
        end else begin
          n_q            <= n_q + 3'd1;
          outport_data_o <= res_q[n_q + 3'd1];
          outport_idx_o  <= {row_q, n_q + 3'd1};
        end
      end
    end
  end

endmodule
